// File: rtl/mux_byte_serializer_pkg.sv
// Shared widths, FSM state encoding and select start/end helpers for the byte serializer.
package mux_byte_serializer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] sel_first(input bit lsb_first);
    return lsb_first ? '0 : '1;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(input bit lsb_first);
    return lsb_first ? '1 : '0;
  endfunction

endpackage

// File: rtl/mux_8to1.sv
// Plain 8:1 bit multiplexer: y is data[sel].
module mux_8to1 (
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       y
);

  always_comb begin
    y = data[sel];
  end

endmodule

// File: rtl/mux_byte_serializer.sv
// Accepts a byte over valid/ready and walks the mux_8to1 select through all eight
// positions, holding each bit CYCLES_PER_BIT cycles with valid/last framing.
module mux_byte_serializer
  import mux_byte_serializer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 1,
  parameter bit          LSB_FIRST      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic [SEL_W-1:0]  select_out,
  output logic              busy
);

  if (CYCLES_PER_BIT == 0 || CYCLES_PER_BIT > 255) begin : g_bad_cycles_per_bit
    $error("mux_byte_serializer: CYCLES_PER_BIT must be in 1..255");
  end

  localparam logic [SEL_W-1:0]  SEL_FIRST = sel_first(LSB_FIRST);
  localparam logic [SEL_W-1:0]  SEL_LAST  = sel_last(LSB_FIRST);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(CYCLES_PER_BIT - 1);

  state_t              state, state_d;
  logic [BYTE_W-1:0]   data_reg, data_d;
  logic [SEL_W-1:0]    sel, sel_d;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic                bit_done;
  logic                byte_done;
  logic                accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      data_reg <= '0;
      sel      <= '0;
      hold     <= '0;
    end else begin
      state    <= state_d;
      data_reg <= data_d;
      sel      <= sel_d;
      hold     <= hold_d;
    end
  end

  // in_ready depends only on registers, so accepting in the final bit cycle
  // gives zero-gap streaming without an input-to-output path.
  always_comb begin
    bit_done  = (hold == HOLD_MAX);
    byte_done = (state == ST_SHIFT) && bit_done && (sel == SEL_LAST);
    in_ready  = (state == ST_IDLE) || byte_done;
    accept    = in_valid && in_ready;

    state_d = state;
    data_d  = data_reg;
    sel_d   = sel;
    hold_d  = hold;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          data_d  = in_data;
          sel_d   = SEL_FIRST;
          hold_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (!bit_done) begin
          hold_d = hold + 8'd1;
        end else if (sel != SEL_LAST) begin
          hold_d = '0;
          sel_d  = LSB_FIRST ? sel + 3'd1 : sel - 3'd1;
        end else if (accept) begin
          data_d = in_data;
          sel_d  = SEL_FIRST;
          hold_d = '0;
        end else begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ser_valid  = (state == ST_SHIFT);
    busy       = (state == ST_SHIFT);
    ser_last   = (state == ST_SHIFT) && (sel == SEL_LAST);
    select_out = sel;
  end

  mux_8to1 u_mux (
    .data (data_reg),
    .sel  (sel),
    .y    (ser_out)
  );

endmodule

// File: tb/tb_mux_byte_serializer.sv
// Directed scoreboard bench for mux_byte_serializer across three parameterisations.
module tb_mux_byte_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data    [3];
  logic       in_valid   [3];
  logic       in_ready   [3];
  logic       ser_out    [3];
  logic       ser_valid  [3];
  logic       ser_last   [3];
  logic [2:0] select_out [3];
  logic       busy       [3];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [2:0] sel;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  // 0: CPB=1 LSB-first, 1: CPB=3 LSB-first, 2: CPB=1 MSB-first
  mux_byte_serializer #(.CYCLES_PER_BIT(1), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_last(ser_last[0]), .select_out(select_out[0]), .busy(busy[0])
  );

  mux_byte_serializer #(.CYCLES_PER_BIT(3), .LSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_last(ser_last[1]), .select_out(select_out[1]), .busy(busy[1])
  );

  mux_byte_serializer #(.CYCLES_PER_BIT(1), .LSB_FIRST(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
    .ser_last(ser_last[2]), .select_out(select_out[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input int unsigned cpb, input bit lsb);
    logic [2:0] s;
    for (int unsigned b = 0; b < 8; b++) begin
      s = lsb ? 3'(b) : 3'(7 - b);
      for (int unsigned h = 0; h < cpb; h++) begin
        sb.push_back('{b: d[s], last: (s == (lsb ? 3'd7 : 3'd0)), sel: s,
                       rdy: (b == 7 && h == cpb - 1)});
      end
    end
  endtask

  task automatic drain(input int k, input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      check("ser_valid", 8'(ser_valid[k]), 8'd1);
      check("busy", 8'(busy[k]), 8'd1);
      check("sb_nonempty", 8'(sb.size() != 0), 8'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ser_out", 8'(ser_out[k]), 8'(e.b));
        check("ser_last", 8'(ser_last[k]), 8'(e.last));
        check("select_out", 8'(select_out[k]), 8'(e.sel));
        check("in_ready", 8'(in_ready[k]), 8'(e.rdy));
      end
      step();
    end
  endtask

  task automatic idle_check(input int k);
    check("idle_ser_valid", 8'(ser_valid[k]), 8'd0);
    check("idle_busy", 8'(busy[k]), 8'd0);
    check("idle_ser_last", 8'(ser_last[k]), 8'd0);
    check("idle_in_ready", 8'(in_ready[k]), 8'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[k]  = 8'h00;
      in_valid[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      idle_check(k);
      check("rst_select_out", 8'(select_out[k]), 8'd0);
      check("rst_ser_out", 8'(ser_out[k]), 8'd0);
    end
    rst_n = 1'b1;
    step();

    // Single byte, CPB=1, LSB first
    in_data[0]  = 8'b1010_1010;
    in_valid[0] = 1'b1;
    check("single_accept_ready", 8'(in_ready[0]), 8'd1);
    step();
    in_valid[0] = 1'b0;
    push_byte(8'b1010_1010, 1, 1'b1);
    drain(0, 8);
    idle_check(0);

    // Back-to-back with in_valid held high
    in_data[0]  = 8'b1010_1010;
    in_valid[0] = 1'b1;
    step();
    in_data[0] = 8'b1100_1100;
    push_byte(8'b1010_1010, 1, 1'b1);
    push_byte(8'b1100_1100, 1, 1'b1);
    drain(0, 8);
    in_valid[0] = 1'b0;
    drain(0, 8);
    idle_check(0);

    // Hold stretch, CPB=3
    in_data[1]  = 8'hF0;
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    push_byte(8'hF0, 3, 1'b1);
    drain(1, 24);
    idle_check(1);

    // MSB first
    in_data[2]  = 8'b1100_1100;
    in_valid[2] = 1'b1;
    step();
    in_valid[2] = 1'b0;
    push_byte(8'b1100_1100, 1, 1'b0);
    drain(2, 8);
    idle_check(2);

    // Busy backpressure: offer 8'hFF while select_out==2
    in_data[0]  = 8'h3C;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    push_byte(8'h3C, 1, 1'b1);
    drain(0, 2);
    check("bp_select_at_2", 8'(select_out[0]), 8'd2);
    in_data[0]  = 8'hFF;
    in_valid[0] = 1'b1;
    drain(0, 1);
    in_valid[0] = 1'b0;
    drain(0, 5);
    idle_check(0);

    // Reset mid-byte between clock edges
    in_data[0]  = 8'h5A;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    push_byte(8'h5A, 1, 1'b1);
    drain(0, 4);
    check("mid_select_at_4", 8'(select_out[0]), 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    idle_check(0);
    check("mid_rst_select_out", 8'(select_out[0]), 8'd0);
    sb.delete();
    #3;
    rst_n = 1'b1;
    step();
    idle_check(0);
    in_data[0]  = 8'h01;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    push_byte(8'h01, 1, 1'b1);
    drain(0, 8);
    idle_check(0);
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
